// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Purpose  : Shared definitions for the sequential divider: FSM state
//            encoding and a constant-width helper for the iteration counter.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_t;

  // Bits needed to count 0 .. value-1 (at least 1).
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration. Shifts the next
//            dividend bit into the partial remainder and trial-subtracts the
//            divisor magnitude with a generate/propagate carry-lookahead adder
//            (inverted divisor, carry-in 1). The adder carry-out means the
//            trial difference is non-negative.
// Ports    : i_rem  [W-1:0] partial remainder entering the step
//            i_bit          next dividend bit (MSB first)
//            i_dsr  [W-1:0] divisor magnitude
//            o_rem  [W-1:0] partial remainder leaving the step
//            o_qbit         quotient bit produced by the step
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  // The incoming remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the kept result fits back in WIDTH bits.
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH:0]   w_g;
  logic [WIDTH:0]   w_p;
  logic [WIDTH+1:0] w_c;
  logic [WIDTH-1:0] w_sum;

  assign w_a    = {i_rem, i_bit};
  assign w_b    = ~{1'b0, i_dsr};
  assign w_g    = w_a & w_b;
  assign w_p    = w_a ^ w_b;
  assign w_c[0] = 1'b1;

  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
      assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  endgenerate

  assign w_sum  = w_p[WIDTH-1:0] ^ w_c[WIDTH-1:0];
  assign o_qbit = w_c[WIDTH+1];
  assign o_rem  = o_qbit ? w_sum : w_a[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle signed/unsigned restoring divider, one quotient bit
//            per cycle, with divide-by-zero reporting.
//            Optional macro SEQ_DIVIDER_OVF_EXC_EN: signed most-negative / -1
//            is reported early with exception set.
// Ports    : clock, reset_n (async, active-low)
//            start, is_signed, dividend, divisor   request (sampled in IDLE)
//            quotient, remainder, exception        results (held)
//            result_rdy                            one-cycle result strobe
//            busy                                  operation in progress
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  localparam int                 c_cnt_w = clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_min   = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t         r_state;
  div_state_t         w_next;
  logic [WIDTH-1:0]   r_dvd;     // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0]   r_dsr;     // divisor magnitude
  logic [WIDTH-1:0]   r_rem;     // partial remainder
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_signed;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_special; // result already produced at start
  logic               w_dbz;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;

  assign w_dbz = (divisor == '0);
`ifdef SEQ_DIVIDER_OVF_EXC_EN
  assign w_ovf = is_signed && (dividend == c_min) && (divisor == '1);
`else
  assign w_ovf = 1'b0;
`endif
  assign w_special = w_dbz | w_ovf;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= DIV_IDLE;
    else          r_state <= w_next;
  end

  // Early-result requests pass through FIX for one cycle so they report
  // ready one edge after acceptance.
  always_comb begin
    w_next     = r_state;
    result_rdy = 1'b0;
    busy       = 1'b1;
    case (r_state)
      DIV_IDLE: begin
        busy = 1'b0;
        if (start) w_next = w_special ? DIV_FIX : DIV_PREP;
      end
      DIV_PREP: w_next = DIV_ITER;
      DIV_ITER: if (r_cnt == c_last) w_next = DIV_FIX;
      DIV_FIX:  w_next = DIV_DONE;
      DIV_DONE: begin
        result_rdy = 1'b1;
        w_next     = DIV_IDLE;
      end
      default:  w_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_special <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      exception <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_dvd     <= dividend;
            r_dsr     <= divisor;
            r_signed  <= is_signed;
            r_special <= w_special;
            if (w_special) begin
              quotient  <= w_dbz ? '0 : c_min;
              remainder <= w_dbz ? dividend : '0;
              exception <= 1'b1;
            end
          end
        end
        DIV_PREP: begin
          if (r_signed) begin
            r_dvd   <= r_dvd[WIDTH-1] ? -r_dvd : r_dvd;
            r_dsr   <= r_dsr[WIDTH-1] ? -r_dsr : r_dsr;
            r_q_neg <= r_dvd[WIDTH-1] ^ r_dsr[WIDTH-1];
            r_r_neg <= r_dvd[WIDTH-1];
          end else begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
          end
          r_rem <= '0;
          r_cnt <= '0;
        end
        DIV_ITER: begin
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
        DIV_FIX: begin
          if (!r_special) begin
            quotient  <= r_q_neg ? -r_dvd : r_dvd;
            remainder <= r_r_neg ? -r_rem : r_rem;
            exception <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider (WIDTH=32): directed cases
//            and randomized operands against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W = 32;

  logic         clock     = 1'b0;
  logic         reset_n   = 1'b0;
  logic         start     = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend  = '0;
  logic [W-1:0] divisor   = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         exception;
  logic         result_rdy;
  logic         busy;

  int vectors = 0;
  int errors  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; lat = edges after acceptance until
  // the ready cycle.
  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic e, output int lat);
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    e   = 1'b0;
    lat = W + 2;
    if (b == '0) begin
      q = '0; r = a; e = 1'b1; lat = 1;
    end else if (sgn && sa == -64'sd2147483648 && sb == -64'sd1) begin
      q = 32'h8000_0000; r = '0;
`ifdef SEQ_DIVIDER_OVF_EXC_EN
      e = 1'b1; lat = 1;
`endif
    end else if (sgn) begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int restart_at, input string tag);
    logic [W-1:0] eq, er;
    logic         ee;
    int           lat;
    model(sgn, a, b, eq, er, ee, lat);
    @(negedge clock);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0; is_signed = ~sgn; dividend = $urandom; divisor = $urandom;
    for (int n = 1; n <= W + 6; n++) begin
      @(posedge clock); #1;
      check({tag, "/rdy"},  W'(result_rdy), W'(n == lat));
      check({tag, "/busy"}, W'(busy),       W'(n <= lat));
      if (n == lat) begin
        check({tag, "/quo"}, quotient,       eq);
        check({tag, "/rem"}, remainder,      er);
        check({tag, "/exc"}, W'(exception),  W'(ee));
      end
      if (n == restart_at - 1) begin
        start = 1'b1; is_signed = ~sgn; dividend = $urandom; divisor = W'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "/quo_hold"}, quotient,  eq);
    check({tag, "/rem_hold"}, remainder, er);
  endtask

  initial begin
    logic         sgn;
    logic [W-1:0] a, b;
    int           sel;

    repeat (3) @(posedge clock);
    #1;
    check("rst/quo",  quotient,        '0);
    check("rst/rem",  remainder,       '0);
    check("rst/exc",  W'(exception),   '0);
    check("rst/rdy",  W'(result_rdy),  '0);
    check("rst/busy", W'(busy),        '0);
    @(negedge clock);
    reset_n = 1'b1;

    run_div(1'b0, 32'd100,         32'd7,          0, "u100_7");
    run_div(1'b1, -32'sd100,       32'd7,          0, "s-100_7");
    run_div(1'b1, 32'd100,         -32'sd7,        0, "s100_-7");
    run_div(1'b0, 32'd5,           32'd0,          0, "u5_0");
    run_div(1'b1, 32'd5,           32'd0,          0, "s5_0");
    run_div(1'b1, 32'h8000_0000,   32'hFFFF_FFFF,  0, "s_ovf");
    run_div(1'b0, 32'h8000_0000,   32'hFFFF_FFFF,  0, "u_minneg");
    run_div(1'b0, 32'hFFFF_FFFF,   32'd1,         10, "u_restart");

    // Reset in the middle of a division.
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort/quo",  quotient,       '0);
    check("abort/rem",  remainder,      '0);
    check("abort/exc",  W'(exception),  '0);
    check("abort/rdy",  W'(result_rdy), '0);
    check("abort/busy", W'(busy),       '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("abort/no_rdy", W'(result_rdy), '0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_div(1'b0, 32'd9, 32'd3, 0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = '1;
        3:       begin a = 32'h8000_0000; b = '1; end
        4:       b = a >> $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
